// File: rtl/mem_frame_packer.sv
// +--------------------------------------------------------------------------+
// | mem_frame_packer                                                         |
// | Packs a valid/ready word stream into a K_DEPTH-word frame image and      |
// | presents it with a valid/ack handshake. Optional early frame close via   |
// | i_last when MEM_FRAME_PACKER_PARTIAL_EN is defined.                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_frame_packer #(
  parameter int K_DWIDTH = 8,
  parameter int K_DEPTH  = 4,
  parameter int K_CWIDTH = $clog2(K_DEPTH + 1)
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [K_DWIDTH-1:0]                i_data,
  input  logic                               i_valid,
`ifdef MEM_FRAME_PACKER_PARTIAL_EN
  input  logic                               i_last,
`endif
  output logic                               o_ready,
  input  logic                               i_flush,
  output logic [K_DEPTH-1:0][K_DWIDTH-1:0]   o_mem,
  output logic                               o_mem_valid,
  input  logic                               i_mem_ack,
  output logic [K_CWIDTH-1:0]                o_count,
  output logic                               o_overflow
);

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  localparam logic [K_CWIDTH-1:0] c_last_idx = K_CWIDTH'(K_DEPTH - 1);

  state_t              r_state;
  logic [K_CWIDTH-1:0] r_cnt;
  logic                w_close;

`ifdef MEM_FRAME_PACKER_PARTIAL_EN
  assign w_close = (r_cnt == c_last_idx) || i_last;
`else
  assign w_close = (r_cnt == c_last_idx);
`endif

  assign o_ready = (r_state == S_FILL);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_FILL;
      r_cnt       <= '0;
      o_mem       <= '0;
      o_mem_valid <= 1'b0;
      o_count     <= '0;
      o_overflow  <= 1'b0;
    end else begin
      if (r_state == S_HOLD && i_valid) begin
        o_overflow <= 1'b1;
      end
      case (r_state)
        S_FILL: begin
          // Flush wins over a coincident accept: the word is dropped.
          if (i_flush) begin
            r_cnt <= '0;
          end else if (i_valid) begin
            for (int i = 0; i < K_DEPTH; i++) begin
              if (K_CWIDTH'(i) == r_cnt) begin
                o_mem[i] <= i_data;
`ifdef MEM_FRAME_PACKER_PARTIAL_EN
              end else if (i_last && (K_CWIDTH'(i) > r_cnt)) begin
                o_mem[i] <= '0;
`endif
              end
            end
            r_cnt <= r_cnt + 1'b1;
            if (w_close) begin
              r_state     <= S_HOLD;
              o_mem_valid <= 1'b1;
              o_count     <= r_cnt + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (i_mem_ack) begin
            r_state     <= S_FILL;
            r_cnt       <= '0;
            o_mem_valid <= 1'b0;
            o_count     <= '0;
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_frame_packer.sv
// +--------------------------------------------------------------------------+
// | tb_mem_frame_packer                                                      |
// | Directed and randomized bench for mem_frame_packer against a queue model.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mem_frame_packer;

  localparam int K_DWIDTH = 8;
  localparam int K_DEPTH  = 4;
  localparam int K_CWIDTH = $clog2(K_DEPTH + 1);

  logic                             i_clk;
  logic                             i_rst;
  logic [K_DWIDTH-1:0]              i_data;
  logic                             i_valid;
`ifdef MEM_FRAME_PACKER_PARTIAL_EN
  logic                             i_last;
`endif
  logic                             o_ready;
  logic                             i_flush;
  logic [K_DEPTH-1:0][K_DWIDTH-1:0] o_mem;
  logic                             o_mem_valid;
  logic                             i_mem_ack;
  logic [K_CWIDTH-1:0]              o_count;
  logic                             o_overflow;

  int checks;
  int errors;

  // Reference model: words of the frame being collected, plus the presented image.
  logic [K_DWIDTH-1:0]              m_words[$];
  logic [K_DEPTH-1:0][K_DWIDTH-1:0] m_mem;
  logic                             m_hold;
  int                               m_count;
  logic                             m_ovf;

  mem_frame_packer #(
    .K_DWIDTH(K_DWIDTH),
    .K_DEPTH (K_DEPTH),
    .K_CWIDTH(K_CWIDTH)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_data     (i_data),
    .i_valid    (i_valid),
`ifdef MEM_FRAME_PACKER_PARTIAL_EN
    .i_last     (i_last),
`endif
    .o_ready    (o_ready),
    .i_flush    (i_flush),
    .o_mem      (o_mem),
    .o_mem_valid(o_mem_valid),
    .i_mem_ack  (i_mem_ack),
    .o_count    (o_count),
    .o_overflow (o_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic model_reset();
    m_words.delete();
    m_mem   = '0;
    m_hold  = 1'b0;
    m_count = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_edge();
    logic last;
    last = 1'b0;
`ifdef MEM_FRAME_PACKER_PARTIAL_EN
    last = i_last;
`endif
    if (i_rst) begin
      model_reset();
    end else if (m_hold) begin
      if (i_valid) m_ovf = 1'b1;
      if (i_mem_ack) begin
        m_hold  = 1'b0;
        m_count = 0;
        m_words.delete();
      end
    end else if (i_flush) begin
      m_words.delete();
    end else if (i_valid) begin
      m_mem[m_words.size()] = i_data;
      m_words.push_back(i_data);
      if (m_words.size() == K_DEPTH || last) begin
        for (int i = m_words.size(); i < K_DEPTH; i++) m_mem[i] = '0;
        m_hold  = 1'b1;
        m_count = m_words.size();
      end
    end
  endtask

  // Advance one clock: update the model with the driven inputs, then settle.
  task automatic cycle();
    @(posedge i_clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    i_valid   = 1'b0;
    i_flush   = 1'b0;
    i_mem_ack = 1'b0;
    i_data    = '0;
`ifdef MEM_FRAME_PACKER_PARTIAL_EN
    i_last    = 1'b0;
`endif
  endtask

  task automatic send_word(input logic [K_DWIDTH-1:0] d);
    i_valid = 1'b1;
    i_data  = d;
    cycle();
    i_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_rst = 1'b1;
    cycle();
    cycle();
    i_rst = 1'b0;
    model_reset();
    cycle();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (o_ready !== 1'b1 || o_mem_valid !== 1'b0 || o_count !== '0 ||
        o_overflow !== 1'b0 || o_mem !== '0) begin
      errors++;
      $display("FAIL reset: ready=%b valid=%b count=%0d ovf=%b mem=%h, required 1 0 0 0 0",
               o_ready, o_mem_valid, o_count, o_overflow, o_mem);
    end
  endtask

  task automatic test_full_frame();
    send_word(8'h11);
    send_word(8'h22);
    send_word(8'h33);
    checks++;
    if (o_mem_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL early_valid: valid=%b ready=%b, required 0 1", o_mem_valid, o_ready);
    end
    send_word(8'h44);
    checks++;
    if (o_mem_valid !== 1'b1 || o_mem !== 32'h44332211 || o_count !== 3'd4 || o_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_frame: valid=%b mem=%h count=%0d ready=%b, required 1 44332211 4 0",
               o_mem_valid, o_mem, o_count, o_ready);
    end
  endtask

  task automatic test_hold_overflow();
    i_valid = 1'b1;
    i_data  = 8'hAA;
    for (int n = 0; n < 10; n++) begin
      cycle();
      checks++;
      if (o_mem !== 32'h44332211 || o_mem_valid !== 1'b1 || o_overflow !== 1'b1 || o_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: mem=%h valid=%b ovf=%b ready=%b, required 44332211 1 1 0",
                 n, o_mem, o_mem_valid, o_overflow, o_ready);
      end
    end
    i_valid   = 1'b0;
    i_mem_ack = 1'b1;
    cycle();
    i_mem_ack = 1'b0;
    checks++;
    if (o_mem_valid !== 1'b0 || o_ready !== 1'b1 || o_count !== '0 || o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ack: valid=%b ready=%b count=%0d ovf=%b, required 0 1 0 1",
               o_mem_valid, o_ready, o_count, o_overflow);
    end
    i_mem_ack = 1'b1;
    cycle();
    i_mem_ack = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || o_mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL stray_ack: ready=%b valid=%b, required 1 0", o_ready, o_mem_valid);
    end
  endtask

  task automatic test_flush();
    send_word(8'h01);
    send_word(8'h02);
    i_flush = 1'b1;
    send_word(8'h03);
    i_flush = 1'b0;
    checks++;
    if (o_mem_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_state: valid=%b ready=%b, required 0 1", o_mem_valid, o_ready);
    end
    for (int w = 4; w <= 7; w++) send_word(K_DWIDTH'(w));
    checks++;
    if (o_mem_valid !== 1'b1 || o_mem !== 32'h07060504 || o_count !== 3'd4) begin
      errors++;
      $display("FAIL flush_frame: valid=%b mem=%h count=%0d, required 1 07060504 4",
               o_mem_valid, o_mem, o_count);
    end
    i_flush = 1'b1;
    cycle();
    i_flush = 1'b0;
    checks++;
    if (o_mem_valid !== 1'b1 || o_mem !== 32'h07060504) begin
      errors++;
      $display("FAIL flush_in_hold: valid=%b mem=%h, required 1 07060504", o_mem_valid, o_mem);
    end
    i_mem_ack = 1'b1;
    cycle();
    i_mem_ack = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int w = 0; w < K_DEPTH; w++) send_word(K_DWIDTH'($urandom_range(1, 255)));
    i_valid = 1'b1;
    cycle();
    i_valid = 1'b0;
    checks++;
    if (o_mem_valid !== 1'b1 || o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_hold: valid=%b ovf=%b, required 1 1", o_mem_valid, o_overflow);
    end
    #2;
    i_rst = 1'b1;
    #1;
    checks++;
    if (o_mem_valid !== 1'b0 || o_count !== '0 || o_overflow !== 1'b0 || o_mem !== '0) begin
      errors++;
      $display("FAIL async_reset: valid=%b count=%0d ovf=%b mem=%h, required 0 0 0 0",
               o_mem_valid, o_count, o_overflow, o_mem);
    end
    cycle();
    i_rst = 1'b0;
    model_reset();
    cycle();
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: ready=%b, required 1", o_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [K_DEPTH-1:0][K_DWIDTH-1:0] frame;
    for (int f = 0; f < 2; f++) begin
      for (int w = 0; w < K_DEPTH; w++) begin
        frame[w] = K_DWIDTH'($urandom);
        send_word(frame[w]);
      end
      checks++;
      if (o_mem_valid !== 1'b1 || o_mem !== frame || o_count !== 3'd4) begin
        errors++;
        $display("FAIL b2b_frame%0d: valid=%b mem=%h count=%0d, required 1 %h 4",
                 f, o_mem_valid, o_mem, o_count, frame);
      end
      i_mem_ack = 1'b1;
      cycle();
      i_mem_ack = 1'b0;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      i_valid   = ($urandom_range(0, 9) < 7);
      i_flush   = ($urandom_range(0, 9) == 0);
      i_mem_ack = ($urandom_range(0, 9) < 3);
      i_data    = K_DWIDTH'($urandom);
`ifdef MEM_FRAME_PACKER_PARTIAL_EN
      i_last    = ($urandom_range(0, 9) < 2);
`endif
      cycle();
      checks++;
      if (o_ready !== !m_hold || o_mem_valid !== m_hold || o_count !== K_CWIDTH'(m_count) ||
          o_overflow !== m_ovf || (m_hold && o_mem !== m_mem)) begin
        errors++;
        $display("FAIL random_cycle%0d: ready=%b valid=%b count=%0d ovf=%b mem=%h, required %b %b %0d %b %h",
                 n, o_ready, o_mem_valid, o_count, o_overflow, o_mem,
                 !m_hold, m_hold, m_count, m_ovf, m_mem);
      end
    end
    idle_inputs();
  endtask

`ifdef MEM_FRAME_PACKER_PARTIAL_EN
  task automatic test_partial();
    do_reset();
    for (int w = 0; w < K_DEPTH; w++) send_word(8'hC0 + K_DWIDTH'(w));
    i_mem_ack = 1'b1;
    cycle();
    i_mem_ack = 1'b0;
    send_word(8'hB1);
    i_last = 1'b1;
    send_word(8'hB2);
    i_last = 1'b0;
    checks++;
    if (o_mem_valid !== 1'b1 || o_count !== 3'd2 || o_mem !== 32'h0000B2B1) begin
      errors++;
      $display("FAIL partial: valid=%b count=%0d mem=%h, required 1 2 0000b2b1",
               o_mem_valid, o_count, o_mem);
    end
    i_mem_ack = 1'b1;
    cycle();
    i_mem_ack = 1'b0;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    i_rst  = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_full_frame();
    test_hold_overflow();
    test_flush();
    test_async_reset();
    test_back_to_back();
    test_random();
`ifdef MEM_FRAME_PACKER_PARTIAL_EN
    test_partial();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
